// File: rtl/sweep_pkg.sv
// Shared types and constants for the exhaustive truth-table sweep sequencer.
// Holds the FSM state encoding and the CRC-16-CCITT polynomial/seed used by sweep_misr.
package sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_FIN   = 2'd2
   } sweep_state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_SEED = 16'hFFFF;

   // One MSB-first serial step of the CCITT LFSR.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/sweep_misr.sv
// Response signature register: serial CRC-16-CCITT compaction of sampled DUT outputs.
// Only instantiated when SWEEP_MISR_EN is defined.
module sweep_misr
   import sweep_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] sig
);

   always_ff @(posedge clk) begin
      if (rst) begin
         sig <= 16'h0000;
      end else if (clr) begin
         sig <= CRC_SEED;
      end else if (en) begin
         sig <= crc16_step(sig, din);
      end
   end

endmodule

// File: rtl/sweep_sequencer.sv
// Exhaustive stimulus sweep of an N-input combinational DUT, capturing its truth table.
// Define SWEEP_MISR_EN to add the CRC-16 response signature on sig; otherwise sig is 0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; results from the last sweep held stable
// ST_DRIVE | driving stim, waiting HOLD-1 cycles, sampling dut_out
// ST_FIN   | one-cycle done pulse, then back to idle
module sweep_sequencer
   import sweep_pkg::*;
#(
   parameter int N    = 3,
   parameter int HOLD = 20
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dut_out,
   output logic [N-1:0]    stim,
   output logic            busy,
   output logic            done,
   output logic [2**N-1:0] tt,
   output logic [N:0]      ones_cnt,
   output logic [15:0]     sig
);

   localparam int          HW        = $clog2(HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [N-1:0]  STIM_LAST = '1;

   sweep_state_t state, state_nxt;
   logic [HW-1:0] hold_cnt;
   logic          accept;
   logic          sample;
   logic          last_vec;

   assign accept   = (state == ST_IDLE) && start;
   assign sample   = (state == ST_DRIVE) && (hold_cnt == HOLD_LAST);
   assign last_vec = (stim == STIM_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            busy = 1'b1;
            if (sample && last_vec) begin
               state_nxt = ST_FIN;
            end
         end
         ST_FIN: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath: stim stays on the last vector after the sweep so it reads back stable in idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         stim     <= '0;
         hold_cnt <= '0;
         tt       <= '0;
         ones_cnt <= '0;
      end else if (accept) begin
         stim     <= '0;
         hold_cnt <= '0;
         tt       <= '0;
         ones_cnt <= '0;
      end else if (state == ST_DRIVE) begin
         if (sample) begin
            tt[stim] <= dut_out;
            ones_cnt <= ones_cnt + (N+1)'(dut_out);
            hold_cnt <= '0;
            if (!last_vec) begin
               stim <= stim + N'(1);
            end
         end else begin
            hold_cnt <= hold_cnt + HW'(1);
         end
      end
   end

`ifdef SWEEP_MISR_EN
   sweep_misr u_misr (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (sample),
      .din (dut_out),
      .sig (sig)
   );
`else
   assign sig = 16'h0000;
`endif

endmodule
